// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block fill controller.
package cache_pkg;

    typedef enum logic {
        FILL_IDLE   = 1'b0,
        FILL_ACTIVE = 1'b1
    } fill_state_t;

    localparam int WORD_BYTES = 2;
    localparam int ADDR_W     = 16;

    function automatic int block_log2(input int block_words);
        return $clog2(block_words);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Wrapping word-index counter for one block fill, with a load value, an enable,
// a terminal-count flag and a sticky done flag.
module fill_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] idx,
    output logic             tc,
    output logic             done
);

    // Steps are counted apart from idx so completion is right even when
    // idx starts in the middle of the block and wraps.
    logic [WIDTH-1:0] steps;

    assign tc = &steps;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            steps <= '0;
            done  <= 1'b0;
        end else if (load) begin
            idx   <= load_value;
            steps <= '0;
            done  <= 1'b0;
        end else if (en && !done) begin
            if (tc) begin
                done <= 1'b1;
            end else begin
                idx   <= idx + WIDTH'(1);
                steps <= steps + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues BLOCK_WORDS reads and writes the
// returned words. Define FILL_CRITICAL_WORD_FIRST_EN to start at the missing word.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 miss_detected,
    input  logic [ADDR_W-1:0]                    miss_address,
    input  logic                                 memory_data_valid,
    output logic                                 fsm_busy,
    output logic                                 mem_read_en,
    output logic [ADDR_W-1:0]                    memory_address,
    output logic                                 write_data_array,
    output logic [block_log2(BLOCK_WORDS)-1:0]   write_word_idx,
    output logic                                 write_tag_array
);

    localparam int IDX_W = block_log2(BLOCK_WORDS);
    localparam int OFF_W = block_log2(BLOCK_WORDS * WORD_BYTES);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    // Latency is a property of the memory; returns are tracked by valid pulses.
    localparam int unused_mem_latency = MEM_LATENCY;

    fill_state_t       state;
    fill_state_t       next_state;
    logic [ADDR_W-1:0] block_base;
    logic [IDX_W-1:0]  start_idx;
    logic              start_fill;
    logic [IDX_W-1:0]  issue_idx;
    logic              issue_tc;
    logic              issue_done;
    logic [IDX_W-1:0]  recv_idx;
    logic              recv_tc;
    logic              recv_done;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = miss_address[OFF_W-1:1];
`else
    assign start_idx = '0;
`endif

    assign start_fill = (state == FILL_IDLE) && miss_detected;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL_IDLE:   if (miss_detected) next_state = FILL_ACTIVE;
            FILL_ACTIVE: if (write_tag_array) next_state = FILL_IDLE;
            default:     next_state = FILL_IDLE;
        endcase
    end

    // Base is block aligned, so adding a word offset never carries out of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            block_base <= '0;
        end else if (start_fill) begin
            block_base <= miss_address & BASE_MASK;
        end
    end

    always_comb begin
        fsm_busy         = (state == FILL_ACTIVE);
        mem_read_en      = (state == FILL_ACTIVE) && !issue_done;
        write_data_array = (state == FILL_ACTIVE) && memory_data_valid && !recv_done;
        write_tag_array  = (state == FILL_ACTIVE) && memory_data_valid && !recv_done && recv_tc;
        memory_address   = '0;
        write_word_idx   = '0;
        if (mem_read_en) begin
            memory_address = block_base + ADDR_W'(WORD_BYTES * int'(issue_idx));
        end
        if (write_data_array) begin
            write_word_idx = recv_idx;
        end
    end

    fill_counter #(
        .WIDTH(IDX_W)
    ) u_issue_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (start_fill),
        .load_value(start_idx),
        .en        (mem_read_en),
        .idx       (issue_idx),
        .tc        (issue_tc),
        .done      (issue_done)
    );

    fill_counter #(
        .WIDTH(IDX_W)
    ) u_recv_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (start_fill),
        .load_value(start_idx),
        .en        (write_data_array),
        .idx       (recv_idx),
        .tc        (recv_tc),
        .done      (recv_done)
    );

    logic unused_issue_tc;
    assign unused_issue_tc = issue_tc;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed spec scenarios plus random
// misses, resets and stray returns, checked every cycle against a fill model.
module tb_cache_fill_fsm;

    localparam int N   = 8;
    localparam int LAT = 4;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    localparam int CWF = 1;
`else
    localparam int CWF = 0;
`endif

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  write_word_idx;
    logic        write_tag_array;

    cache_fill_fsm #(
        .BLOCK_WORDS(N),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_word_idx   (write_word_idx),
        .write_tag_array  (write_tag_array)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pend[$];

    // Fill model: a fill is a base, a start offset and counts of reads/returns.
    int m_busy = 0;
    int m_base = 0;
    int m_off = 0;
    int m_issued = 0;
    int m_recv = 0;
    int e_rd, e_addr, e_wr, e_idx, e_tag;
    int obs_busy, obs_rd, obs_addr, obs_wr, obs_idx, obs_tag;

    task automatic checkValue(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic checkOutput();
        e_rd   = (m_busy != 0 && m_issued < N) ? 1 : 0;
        e_addr = (e_rd != 0) ? ((m_base + 2 * ((m_off + m_issued) % N)) & 16'hFFFF) : 0;
        e_wr   = (m_busy != 0 && memory_data_valid) ? 1 : 0;
        e_idx  = (e_wr != 0) ? ((m_off + m_recv) % N) : 0;
        e_tag  = (e_wr != 0 && m_recv == N - 1) ? 1 : 0;
        obs_busy = int'(fsm_busy);
        obs_rd   = int'(mem_read_en);
        obs_addr = int'(memory_address);
        obs_wr   = int'(write_data_array);
        obs_idx  = int'(write_word_idx);
        obs_tag  = int'(write_tag_array);
        checkValue("model busy", obs_busy, m_busy);
        checkValue("model read_en", obs_rd, e_rd);
        checkValue("model address", obs_addr, e_addr);
        checkValue("model write", obs_wr, e_wr);
        checkValue("model word_idx", obs_idx, e_idx);
        checkValue("model tag", obs_tag, e_tag);
    endtask

    function automatic void modelStep();
        int a;
        a = int'(miss_address);
        if (rst) begin
            m_busy = 0;
        end else if (m_busy == 0) begin
            if (miss_detected) begin
                m_busy   = 1;
                m_base   = a - (a % (2 * N));
                m_off    = ((a / 2) % N) * CWF;
                m_issued = 0;
                m_recv   = 0;
            end
        end else begin
            m_issued += e_rd;
            m_recv   += e_wr;
            if (m_recv == N) m_busy = 0;
        end
    endfunction

    // One cycle: drive inputs at the falling edge, compare, then advance the model.
    task automatic applyStimulus(input bit r, input bit m, input logic [15:0] a, input bit stray);
        bit v;
        @(negedge clk);
        v = 1'b0;
        if (pend.size() > 0 && pend[0] == cyc) begin
            v = 1'b1;
            void'(pend.pop_front());
        end
        if (stray && m_busy == 0 && pend.size() == 0) v = 1'b1;
        rst               = r;
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        #1;
        checkOutput();
        if (mem_read_en) pend.push_back(cyc + LAT);
        modelStep();
        @(posedge clk);
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        int nreads;
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        memory_data_valid = 1'b0;

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkValue("reset busy", obs_busy, 0);
        checkValue("reset read_en", obs_rd, 0);
        checkValue("reset address", obs_addr, 0);
        checkValue("reset write", obs_wr, 0);
        checkValue("reset tag", obs_tag, 0);

        // Basic fill at 0x1236 with the literal cycle-by-cycle timeline.
        for (int k = 0; k <= 13; k++) begin
            applyStimulus(1'b0, k == 0, 16'h1236, 1'b0);
            checkValue("A busy", obs_busy, int'(k >= 1 && k <= 12));
            checkValue("A read_en", obs_rd, int'(k >= 1 && k <= 8));
            checkValue("A address", obs_addr,
                       (k >= 1 && k <= 8) ? 16'h1230 + 2 * ((k - 1 + 3 * CWF) % 8) : 0);
            checkValue("A write", obs_wr, int'(k >= 5 && k <= 12));
            checkValue("A word_idx", obs_idx, (k >= 5 && k <= 12) ? (k - 5 + 3 * CWF) % 8 : 0);
            checkValue("A tag", obs_tag, int'(k == 12));
        end
        idleCycles(4);

        // Miss held through a fill; a new address appears on the final write.
        nreads = 0;
        for (int k = 0; k <= 14; k++) begin
            applyStimulus(1'b0, 1'b1, (k >= 12) ? 16'h0080 : 16'h0040, 1'b0);
            if (k >= 1 && k <= 13) begin
                nreads += obs_rd;
                if (obs_rd != 0) checkValue("B address in block", int'(obs_addr >= 16'h0040 && obs_addr <= 16'h004E), 1);
            end
        end
        checkValue("B read count", nreads, 8);
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        idleCycles(8);

        // Reset in the middle of a fill.
        for (int k = 0; k <= 20; k++) begin
            applyStimulus(k == 6, k == 0, 16'h2000, 1'b0);
            if (k == 7) begin
                checkValue("C busy after reset", obs_busy, 0);
                checkValue("C read_en after reset", obs_rd, 0);
                checkValue("C address after reset", obs_addr, 0);
                checkValue("C word_idx after reset", obs_idx, 0);
            end
            if (k >= 7) begin
                checkValue("C write after reset", obs_wr, 0);
                checkValue("C tag after reset", obs_tag, 0);
            end
        end

        // Stray return while idle, then a fresh fill must start at word 0.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkValue("D stray write", obs_wr, 0);
        for (int k = 0; k <= 13; k++) begin
            applyStimulus(1'b0, k == 0, 16'h0100, 1'b0);
            if (k == 5) begin
                checkValue("D first write", obs_wr, 1);
                checkValue("D first word_idx", obs_idx, 0);
            end
            if (k == 12) checkValue("D tag", obs_tag, 1);
        end
        idleCycles(4);

        // Top-of-memory block.
        for (int k = 0; k <= 13; k++) begin
            applyStimulus(1'b0, k == 0, 16'hFFFE, 1'b0);
            if (k == 1) checkValue("E first address", obs_addr, 16'hFFF0 + 14 * CWF);
            if (obs_rd != 0) checkValue("E address in block", int'(obs_addr >= 16'hFFF0 && obs_addr <= 16'hFFFE), 1);
            if (k == 12) checkValue("E tag", obs_tag, 1);
        end
        idleCycles(4);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                          16'($urandom), $urandom_range(0, 7) == 0);
        end
        idleCycles(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
